motor_pwm_drv: RTL and testbench

H-bridge PWM driver that sits directly downstream of the IR-sensor direction sequencer. It consumes that block's `en` (motor enable) and `dir` (1 = forward, 0 = backward) and produces the two H-bridge input signals. It also:
- ramps duty up and down so the motor soft-starts and soft-stops;
- forces a full ramp-down plus a dead interval before any direction reversal;
- guarantees the two bridge inputs are never high together.

---
 rtl/motor_pwm_drv_if.sv | 14 +
 rtl/motor_pwm_drv.sv | 137 +++++++++++++
 tb/tb_motor_pwm_drv.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/motor_pwm_drv_if.sv
// Command and H-bridge drive bundle between the direction sequencer (master)
// and the PWM driver (slave).
interface motor_pwm_drv_if;
  logic en;
  logic dir;
  logic in_a;
  logic in_b;
  logic busy;
  logic at_speed;
  logic dir_act;

  modport master (output en, dir, input in_a, in_b, busy, at_speed, dir_act);
  modport slave  (input en, dir, output in_a, in_b, busy, at_speed, dir_act);
endinterface

// File: rtl/motor_pwm_drv.sv
// H-bridge PWM driver with soft start/stop ramps and a forced coast interval
// before any restart, so the bridge never sees a hard reversal.
module motor_pwm_drv #(
  parameter int PERIOD   = 250,
  parameter int DUTY_MAX = 200,
  parameter int RAMP_DIV = 100,
  parameter int DEAD     = 50,
  parameter int CW       = 8
) (
  input  logic           CLK,
  input  logic           RSTn,
  motor_pwm_drv_if.slave drv
);
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RAMPUP, S_RUN, S_RAMPDN, S_DEAD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_q, duty_d;
  logic [CW-1:0] duty_sh_q, duty_sh_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          dir_act_q, dir_act_d;
  logic          in_a_q, in_a_d, in_b_q, in_b_d;
  logic          busy_q, busy_d, at_speed_q, at_speed_d;
  logic          tick, stop_req, driving, pwm_on;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    dir_act_d = dir_act_q;
    dcnt_d    = dcnt_q;
    tick      = (pre_q == PW'(RAMP_DIV - 1));
    stop_req  = !drv.en || (drv.dir != dir_act_q);

    unique case (state_q)
      S_IDLE: begin
        duty_d = '0;
        if (drv.en) begin
          dir_act_d = drv.dir;
          state_d   = S_RAMPUP;
        end
      end
      S_RAMPUP: begin
        // A resume straight out of a fresh ramp-down can arrive at full duty.
        if (stop_req) state_d = S_RAMPDN;
        else if (duty_q == CW'(DUTY_MAX)) state_d = S_RUN;
        else if (tick) begin
          duty_d = duty_q + 1'b1;
          if (duty_d == CW'(DUTY_MAX)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        duty_d = CW'(DUTY_MAX);
        if (stop_req) state_d = S_RAMPDN;
      end
      S_RAMPDN: begin
        if (!stop_req) state_d = S_RAMPUP;
        else if (duty_q == '0) state_d = S_DEAD;
        else if (tick) begin
          duty_d = duty_q - 1'b1;
          if (duty_d == '0) state_d = S_DEAD;
        end
      end
      S_DEAD: begin
        if (dcnt_q == '0) begin
          if (drv.en) begin
            dir_act_d = drv.dir;
            duty_d    = '0;
            state_d   = S_RAMPUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DEAD && state_q != S_DEAD) dcnt_d = DW'(DEAD - 1);
    pre_d = (tick || state_d != state_q) ? '0 : pre_q + 1'b1;

    cnt_d   = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    driving = (state_q == S_RAMPUP) || (state_q == S_RUN) || (state_q == S_RAMPDN);
    // Shadow is cleared while coasting so a restart never inherits a stale pulse.
    if (!driving) duty_sh_d = '0;
    else if (cnt_q == CW'(PERIOD - 1)) duty_sh_d = duty_q;
    else duty_sh_d = duty_sh_q;

    pwm_on     = driving && (cnt_q < duty_sh_q);
    in_a_d     = pwm_on && dir_act_q;
    in_b_d     = pwm_on && !dir_act_q;
    busy_d     = (state_q != S_IDLE);
    at_speed_d = (state_q == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      duty_q     <= '0;
      duty_sh_q  <= '0;
      pre_q      <= '0;
      dcnt_q     <= '0;
      dir_act_q  <= 1'b1;
      in_a_q     <= 1'b0;
      in_b_q     <= 1'b0;
      busy_q     <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      duty_sh_q  <= duty_sh_d;
      pre_q      <= pre_d;
      dcnt_q     <= dcnt_d;
      dir_act_q  <= dir_act_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      busy_q     <= busy_d;
      at_speed_q <= at_speed_d;
    end
  end

  assign drv.in_a     = in_a_q;
  assign drv.in_b     = in_b_q;
  assign drv.busy     = busy_q;
  assign drv.at_speed = at_speed_q;
  assign drv.dir_act  = dir_act_q;
endmodule

// File: tb/tb_motor_pwm_drv.sv
// Directed bench for motor_pwm_drv: expectations queued at stimulus time,
// popped at each sample point, plus a bridge-safety monitor.
module tb_motor_pwm_drv;
  localparam int PERIOD = 10, DUTY_MAX = 8, RAMP_DIV = 4, DEAD = 5, CW = 8;

  logic CLK, RSTn;
  motor_pwm_drv_if bus ();

  motor_pwm_drv #(.PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX), .RAMP_DIV(RAMP_DIV),
                  .DEAD(DEAD), .CW(CW)) dut (.CLK(CLK), .RSTn(RSTn), .drv(bus));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_entry_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Bridge safety: never both high, and a direction change leaves >= DEAD quiet cycles.
  int cyc = 0, last_a = -1000, last_b = -1000;
  always @(negedge CLK) begin
    cyc++;
    if (RSTn === 1'b1 && (bus.in_a === 1'b1 || bus.in_b === 1'b1)) begin
      checks++;
      assert ((bus.in_a & bus.in_b) === 1'b0) else begin
        errors++;
        $error("FAIL overlap observed=%b%b expected=not 11", bus.in_a, bus.in_b);
      end
      if (bus.in_b === 1'b1 && last_a > last_b) begin
        checks++;
        assert ((cyc - last_a - 1 >= DEAD) === 1'b1) else begin
          errors++;
          $error("FAIL gap_a_to_b observed=%0d expected>=%0d", cyc - last_a - 1, DEAD);
        end
      end
      if (bus.in_a === 1'b1 && last_b > last_a) begin
        checks++;
        assert ((cyc - last_b - 1 >= DEAD) === 1'b1) else begin
          errors++;
          $error("FAIL gap_b_to_a observed=%0d expected>=%0d", cyc - last_b - 1, DEAD);
        end
      end
      if (bus.in_a === 1'b1) last_a = cyc;
      if (bus.in_b === 1'b1) last_b = cyc;
    end
  end

  int na, nb, nq;

  initial begin
    RSTn = 1'b1; bus.en = 1'b0; bus.dir = 1'b0;
    #1 RSTn = 1'b0;
    step(2);
    push("rst_in_a", 0);     check(bus.in_a);
    push("rst_in_b", 0);     check(bus.in_b);
    push("rst_busy", 0);     check(bus.busy);
    push("rst_at_speed", 0); check(bus.at_speed);
    push("rst_dir_act", 1);  check(bus.dir_act);
    RSTn = 1'b1;
    step(2);

    // Forward soft start from idle
    bus.en = 1'b1; bus.dir = 1'b1;
    push("fwd_busy_e1", 0);    step(1);  check(bus.busy);
    push("fwd_busy_e2", 1);    step(1);  check(bus.busy);
    push("fwd_atspd_e33", 0);  step(31); check(bus.at_speed);
    push("fwd_atspd_e34", 1);  step(1);  check(bus.at_speed);
    step(20);
    na = 0; nb = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step(1); na += int'(bus.in_a); nb += int'(bus.in_b);
    end
    push("fwd_run_a_highs", DUTY_MAX); check(na);
    push("fwd_run_b_highs", 0);        check(nb);

    // Stop: ramp down, dead interval, idle
    bus.en = 1'b0;
    push("stop_atspd_f1", 1); step(1); check(bus.at_speed);
    push("stop_atspd_f2", 0); step(1); check(bus.at_speed);
    step(31);
    nq = 0;
    for (int i = 0; i < DEAD; i++) begin
      step(1); nq += int'(bus.in_a | bus.in_b);
    end
    push("stop_dead_quiet", 0); check(nq);
    push("stop_busy_f38", 1);   check(bus.busy);
    push("stop_busy_f39", 0);   step(1); check(bus.busy);

    // Reversal forward -> backward while enabled
    step(2);
    bus.en = 1'b1; bus.dir = 1'b1;
    for (int i = 0; i < 100 && bus.at_speed !== 1'b1; i++) step(1);
    push("rev_fwd_at_speed", 1); check(bus.at_speed);
    step(5);
    bus.dir = 1'b0;
    step(37);
    push("rev_dir_g37", 1);    check(bus.dir_act);
    push("rev_dir_g38", 0);    step(1);  check(bus.dir_act);
    push("rev_busy_g38", 1);   check(bus.busy);
    push("rev_atspd_g70", 0);  step(32); check(bus.at_speed);
    push("rev_atspd_g71", 1);  step(1);  check(bus.at_speed);
    step(20);
    na = 0; nb = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step(1); na += int'(bus.in_a); nb += int'(bus.in_b);
    end
    push("rev_run_b_highs", DUTY_MAX); check(nb);
    push("rev_run_a_highs", 0);        check(na);
    bus.en = 1'b0;
    for (int i = 0; i < 100 && bus.busy !== 1'b0; i++) step(1);
    push("rev_stop_idle", 0); check(bus.busy);
    step(3);

    // Short enable: ramp-down from zero duty, dead, idle, no pulses
    bus.en = 1'b1; bus.dir = 1'b1;
    nq = 0;
    push("short_busy_h1", 0); step(1); check(bus.busy);
    nq += int'(bus.in_a | bus.in_b);
    push("short_dir_h1", 1);  check(bus.dir_act);
    push("short_busy_h2", 1); step(1); check(bus.busy);
    nq += int'(bus.in_a | bus.in_b);
    bus.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1); nq += int'(bus.in_a | bus.in_b);
    end
    push("short_busy_h9", 1);  check(bus.busy);
    push("short_busy_h10", 0); step(1); check(bus.busy);
    nq += int'(bus.in_a | bus.in_b);
    push("short_no_pulse", 0); check(nq);

    // Resume mid ramp-down at duty 4 (backward)
    step(2);
    bus.en = 1'b1; bus.dir = 1'b0;
    for (int i = 0; i < 100 && bus.at_speed !== 1'b1; i++) step(1);
    push("res_at_speed", 1); check(bus.at_speed);
    push("res_dir_act", 0);  check(bus.dir_act);
    step(3);
    bus.en = 1'b0;
    push("res_atspd_j2", 0); step(2); check(bus.at_speed);
    step(15);
    bus.en = 1'b1;
    push("res_busy_j18", 1);   step(1);  check(bus.busy);
    push("res_atspd_j34", 0);  step(16); check(bus.at_speed);
    push("res_atspd_j35", 1);  step(1);  check(bus.at_speed);

    // Asynchronous reset in the middle of a pulse
    for (int i = 0; i < 3 * PERIOD && bus.in_b !== 1'b1; i++) step(1);
    push("pre_rst_in_b", 1); check(bus.in_b);
    #2 RSTn = 1'b0;
    #1;
    push("arst_in_a", 0);     check(bus.in_a);
    push("arst_in_b", 0);     check(bus.in_b);
    push("arst_busy", 0);     check(bus.busy);
    push("arst_at_speed", 0); check(bus.at_speed);
    push("arst_dir_act", 1);  check(bus.dir_act);
    bus.en = 1'b0;
    step(2);
    RSTn = 1'b1;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
